// File: rtl/rgb_ycc_pkg.sv
// rtl/rgb_ycc_pkg.sv - shared constants and per-channel coefficient table for rgb_to_ycbcr
package rgb_ycc_pkg;

  localparam int PIX_W     = 8;
  localparam int FRAC_BITS = 8;
  localparam int PROD_W    = 16;
  localparam int SUM_W     = 18;

  localparam logic [PIX_W-1:0] Y_R  = 8'd77;
  localparam logic [PIX_W-1:0] Y_G  = 8'd150;
  localparam logic [PIX_W-1:0] Y_B  = 8'd29;
  localparam logic [PIX_W-1:0] CB_R = 8'd43;
  localparam logic [PIX_W-1:0] CB_G = 8'd85;
  localparam logic [PIX_W-1:0] CB_B = 8'd128;
  localparam logic [PIX_W-1:0] CR_R = 8'd128;
  localparam logic [PIX_W-1:0] CR_G = 8'd107;
  localparam logic [PIX_W-1:0] CR_B = 8'd21;

  // Chroma offset folds the +128 centre and the rounding half-LSB into one constant.
  localparam logic [SUM_W-1:0] LUMA_OFFSET   = 18'd128;
  localparam logic [SUM_W-1:0] CHROMA_OFFSET = 18'd32896;

  localparam logic signed [SUM_W-1:0] PIX_MAX = 18'sd255;

  typedef enum logic [1:0] {
    CH_Y,
    CH_CB,
    CH_CR
  } ycc_sel_e;

  typedef struct packed {
    logic [PIX_W-1:0] coef_r;
    logic [PIX_W-1:0] coef_g;
    logic [PIX_W-1:0] coef_b;
    logic             neg_r;
    logic             neg_g;
    logic             neg_b;
    logic [SUM_W-1:0] offset;
  } chan_cfg_t;

  function automatic chan_cfg_t chan_cfg(input ycc_sel_e sel);
    chan_cfg_t cfg;
    case (sel)
      CH_CB:   cfg = '{coef_r: CB_R, coef_g: CB_G, coef_b: CB_B,
                       neg_r: 1'b1, neg_g: 1'b1, neg_b: 1'b0, offset: CHROMA_OFFSET};
      CH_CR:   cfg = '{coef_r: CR_R, coef_g: CR_G, coef_b: CR_B,
                       neg_r: 1'b0, neg_g: 1'b1, neg_b: 1'b1, offset: CHROMA_OFFSET};
      default: cfg = '{coef_r: Y_R, coef_g: Y_G, coef_b: Y_B,
                       neg_r: 1'b0, neg_g: 1'b0, neg_b: 1'b0, offset: LUMA_OFFSET};
    endcase
    return cfg;
  endfunction

  function automatic logic signed [SUM_W-1:0] signed_term(input logic [PROD_W-1:0] prod,
                                                         input logic              neg);
    logic signed [SUM_W-1:0] ext;
    ext = $signed({{(SUM_W-PROD_W){1'b0}}, prod});
    return neg ? -ext : ext;
  endfunction

endpackage

// File: rtl/ycc_channel.sv
// rtl/ycc_channel.sv - one output channel: registered products, then sum/offset/shift/clamp register
module ycc_channel
  import rgb_ycc_pkg::*;
#(
  parameter ycc_sel_e SEL = CH_Y
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] red_ch,
  input  logic [PIX_W-1:0] green_ch,
  input  logic [PIX_W-1:0] blue_ch,
  output logic [PIX_W-1:0] dout
);

  localparam chan_cfg_t CFG = chan_cfg(SEL);
  localparam logic [PROD_W-PIX_W-1:0] PAD = '0;

  logic [PROD_W-1:0]       prod_r_d, prod_r_q;
  logic [PROD_W-1:0]       prod_g_d, prod_g_q;
  logic [PROD_W-1:0]       prod_b_d, prod_b_q;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;
  logic [PIX_W-1:0]        dout_d, dout_q;

  always_comb begin
    prod_r_d = {PAD, red_ch}   * {PAD, CFG.coef_r};
    prod_g_d = {PAD, green_ch} * {PAD, CFG.coef_g};
    prod_b_d = {PAD, blue_ch}  * {PAD, CFG.coef_b};
  end

  // Zeroed products after reset leave only the offset, giving black (0/128/128).
  always_comb begin
    sum = signed_term(prod_r_q, CFG.neg_r)
        + signed_term(prod_g_q, CFG.neg_g)
        + signed_term(prod_b_q, CFG.neg_b)
        + $signed(CFG.offset);
    shifted = sum >>> FRAC_BITS;
    if (shifted[SUM_W-1]) begin
      dout_d = '0;
    end else if (shifted > PIX_MAX) begin
      dout_d = '1;
    end else begin
      dout_d = shifted[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      dout_q   <= '0;
    end else begin
      prod_r_q <= prod_r_d;
      prod_g_q <= prod_g_d;
      prod_b_q <= prod_b_d;
      dout_q   <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/rgb_to_ycbcr.sv
// rtl/rgb_to_ycbcr.sv - two-stage BT.601 full-range RGB to YCbCr converter, one pixel per clock
module rgb_to_ycbcr
  import rgb_ycc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] red_ch,
  input  logic [PIX_W-1:0] green_ch,
  input  logic [PIX_W-1:0] blue_ch,
  output logic [PIX_W-1:0] luma_ch,
  output logic [PIX_W-1:0] cb_ch,
  output logic [PIX_W-1:0] cr_ch
);

  ycc_channel #(.SEL(CH_Y)) u_luma (
    .clk      (clk),
    .rst      (rst),
    .red_ch   (red_ch),
    .green_ch (green_ch),
    .blue_ch  (blue_ch),
    .dout     (luma_ch)
  );

  ycc_channel #(.SEL(CH_CB)) u_cb (
    .clk      (clk),
    .rst      (rst),
    .red_ch   (red_ch),
    .green_ch (green_ch),
    .blue_ch  (blue_ch),
    .dout     (cb_ch)
  );

  ycc_channel #(.SEL(CH_CR)) u_cr (
    .clk      (clk),
    .rst      (rst),
    .red_ch   (red_ch),
    .green_ch (green_ch),
    .blue_ch  (blue_ch),
    .dout     (cr_ch)
  );

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// tb/tb_rgb_to_ycbcr.sv - directed self-checking bench for rgb_to_ycbcr
module tb_rgb_to_ycbcr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] red_ch = '0;
  logic [7:0] green_ch = '0;
  logic [7:0] blue_ch = '0;
  logic [7:0] luma_ch;
  logic [7:0] cb_ch;
  logic [7:0] cr_ch;

  int checks = 0;
  int errors = 0;

  rgb_to_ycbcr dut (
    .clk      (clk),
    .rst      (rst),
    .red_ch   (red_ch),
    .green_ch (green_ch),
    .blue_ch  (blue_ch),
    .luma_ch  (luma_ch),
    .cb_ch    (cb_ch),
    .cr_ch    (cr_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] rgb);
    {red_ch, green_ch, blue_ch} = rgb;
  endtask

  task automatic test_reset();
    logic [23:0] exp_v [4];
    exp_v = '{24'h000000, 24'h000000, 24'h008080, 24'h008080};
    rst = 1'b1;
    drive(24'h000000);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      checks++;
      if ({luma_ch, cb_ch, cr_ch} !== exp_v[i]) begin
        errors++;
        $display("FAIL reset[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                 luma_ch, cb_ch, cr_ch, exp_v[i][23:16], exp_v[i][15:8], exp_v[i][7:0]);
      end
    end
  endtask

  task automatic test_pair();
    logic [23:0] pix [2];
    logic [23:0] exp_v [2];
    pix   = '{{8'd111, 8'd3, 8'd122}, {8'd121, 8'd3, 8'd2}};
    exp_v = '{{8'd49, 8'd169, 8'd172}, {8'd38, 8'd108, 8'd187}};
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(pix[i]);
      tick();
      if (i >= 1) begin
        checks++;
        if ({luma_ch, cb_ch, cr_ch} !== exp_v[i-1]) begin
          errors++;
          $display("FAIL pair[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i-1,
                   luma_ch, cb_ch, cr_ch, exp_v[i-1][23:16], exp_v[i-1][15:8], exp_v[i-1][7:0]);
        end
      end
    end
  endtask

  task automatic test_full_range();
    logic [23:0] pix [2];
    logic [23:0] exp_v [2];
    pix   = '{24'hFFFFFF, 24'h000000};
    exp_v = '{{8'd255, 8'd128, 8'd128}, {8'd0, 8'd128, 8'd128}};
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(pix[i]);
      tick();
      if (i >= 1) begin
        checks++;
        if ({luma_ch, cb_ch, cr_ch} !== exp_v[i-1]) begin
          errors++;
          $display("FAIL full_range[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i-1,
                   luma_ch, cb_ch, cr_ch, exp_v[i-1][23:16], exp_v[i-1][15:8], exp_v[i-1][7:0]);
        end
      end
    end
  endtask

  task automatic test_clamp();
    logic [23:0] pix [2];
    logic [23:0] exp_v [2];
    pix   = '{24'h0000FF, 24'hFF0000};
    exp_v = '{{8'd29, 8'd255, 8'd107}, {8'd77, 8'd85, 8'd255}};
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(pix[i]);
      tick();
      if (i >= 1) begin
        checks++;
        if ({luma_ch, cb_ch, cr_ch} !== exp_v[i-1]) begin
          errors++;
          $display("FAIL clamp[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i-1,
                   luma_ch, cb_ch, cr_ch, exp_v[i-1][23:16], exp_v[i-1][15:8], exp_v[i-1][7:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pix [6];
    logic [23:0] exp_v [6];
    pix   = '{{8'd111, 8'd3, 8'd122}, {8'd121, 8'd3, 8'd2}, 24'hFFFFFF,
              24'h0000FF, 24'hFF0000, 24'h00FF00};
    exp_v = '{{8'd49, 8'd169, 8'd172}, {8'd38, 8'd108, 8'd187}, {8'd255, 8'd128, 8'd128},
              {8'd29, 8'd255, 8'd107}, {8'd77, 8'd85, 8'd255}, {8'd149, 8'd43, 8'd21}};
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(pix[i]);
      tick();
      if (i >= 1) begin
        checks++;
        if ({luma_ch, cb_ch, cr_ch} !== exp_v[i-1]) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i-1,
                   luma_ch, cb_ch, cr_ch, exp_v[i-1][23:16], exp_v[i-1][15:8], exp_v[i-1][7:0]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] exp_v [4];
    exp_v = '{24'h000000, {8'd0, 8'd128, 8'd128}, {8'd29, 8'd255, 8'd107}, {8'd77, 8'd85, 8'd255}};
    drive(24'hFFFFFF);
    tick();
    drive({8'd111, 8'd3, 8'd122});
    tick();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin rst = 1'b1; drive({8'd121, 8'd3, 8'd2}); end
        1:       begin rst = 1'b0; drive(24'h0000FF); end
        2:       drive(24'hFF0000);
        default: drive(24'h000000);
      endcase
      tick();
      checks++;
      if ({luma_ch, cb_ch, cr_ch} !== exp_v[i]) begin
        errors++;
        $display("FAIL mid_reset[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                 luma_ch, cb_ch, cr_ch, exp_v[i][23:16], exp_v[i][15:8], exp_v[i][7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_full_range();
    test_clamp();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
